breaker_trip_interface: RTL and testbench
=========================================

Name: breaker_trip_interface

Overview:
Breaker-side counterpart to the latching instantaneous overcurrent relay. It consumes the relay's latched trip_signal and drives the trip and close coils. It monitors the breaker auxiliary (52a) contact and detects breaker failure. Once the breaker is confirmed open, it issues a relay_reset_req pulse that clears the relay latch. It sits between the relay emulation and the breaker I/O pins, in the clk_800hz domain.

Parameters:
COIL_PULSE_CYC, 16, coil energise length in cycles (20 ms at 800 Hz).
BF_TIMEOUT_CYC, 80, cycles allowed for the contact to confirm a trip or close (100 ms); must exceed COIL_PULSE_CYC.
DEBOUNCE_CYC, 4, consecutive equal synchronised samples required to accept a contact change.
RECLOSE_DELAY_CYC, 400, dead time and reclaim time for the optional auto-reclose (500 ms).
CNT_W, 12, width of the shared state timer; must hold the largest cycle parameter.

Ports:
clk_800hz  in  1  800 Hz system clock
reset_n  in  1  asynchronous, active-low reset
trip_signal  in  1  latched trip from the overcurrent relay
breaker_closed_raw  in  1  52a auxiliary contact, asynchronous; 1 = closed
manual_close  in  1  operator close request, level; rising edge is used
trip_coil  out  1  trip coil drive
close_coil  out  1  close coil drive
breaker_open  out  1  debounced breaker status; 1 = open
relay_reset_req  out  1  one-cycle pulse that clears the relay latch
breaker_fail  out  1  latched breaker-failure flag
lockout  out  1  lockout flag; cleared only by reset_n
state  out  3  FSM state: CLOSED=0, TRIPPING=1, OPEN=2, CLOSING=3, LOCKOUT=4

Behaviour:
- Reset (async assert, sync release):
  - state=CLOSED, timer=0.
  - All outputs 0 except breaker_open=0 (debounced closed=1).
  - Sync flops and debounce register preset to "closed".
- Contact path:
  - 2-FF synchroniser, then a debounce counter.
  - Debounced value changes DEBOUNCE_CYC edges after the synchronised value settles, i.e. 2+DEBOUNCE_CYC edges after the raw change.
  - Any mismatching sample restarts the count.
- All outputs are registered. The timer clears on every state entry, increments each cycle and saturates at all-ones.
- CLOSED:
  - trip_signal=1 -> TRIPPING; trip_coil=1 from the same edge.
  - Debounced open without a trip -> OPEN (spontaneous opening; no relay_reset_req).
  - manual_close is ignored.
- TRIPPING:
  - trip_coil=1 while timer<COIL_PULSE_CYC, then 0.
  - Debounced open -> OPEN; trip_coil=0 and a relay_reset_req pulse on the entry edge.
  - Timer reaches BF_TIMEOUT_CYC while still closed -> LOCKOUT with breaker_fail=1.
- OPEN:
  - breaker_open=1.
  - Rising edge of manual_close with trip_signal=0 -> CLOSING. If trip_signal=1, the close request is discarded.
  - Debounced closed without a close command -> CLOSED.
- CLOSING:
  - close_coil=1 while timer<COIL_PULSE_CYC.
  - Debounced closed -> CLOSED, close_coil=0.
  - Timer reaches BF_TIMEOUT_CYC without closing -> LOCKOUT with breaker_fail=1.
  - trip_signal=1 at any point -> TRIPPING at the same edge; close_coil drops and trip_coil rises.
- LOCKOUT:
  - lockout=1; both coils 0; all inputs ignored.
  - Exit only via reset_n.
- Simultaneous events:
  - Trip beats close in every state.
  - A debounce change and a timeout on the same edge resolve in favour of the contact, so no fail is flagged.
- trip_coil and close_coil are never both 1 (mutual exclusion is an invariant).
- Reset asserted mid-pulse deasserts both coils immediately.

Optional Feature:
AUTO_RECLOSE_EN.
- Defined:
  - One-shot auto-reclose. After an OPEN entered from TRIPPING, wait RECLOSE_DELAY_CYC, then enter CLOSING as if manual_close had occurred, provided trip_signal=0.
  - A shot_used flag sets on that attempt. It clears after the breaker has stayed CLOSED for RECLOSE_DELAY_CYC.
  - A trip while shot_used=1 goes TRIPPING -> LOCKOUT once the contact opens, with lockout=1 and breaker_fail=0. relay_reset_req still pulses.
- Undefined:
  - No auto-reclose, no shot flag; only manual_close recloses.

Test Plan:
- Trip: raw closed, trip_signal 0->1 -> trip_coil=1 next edge, 16 cycles high. Raw opens at cycle 5 -> breaker_open=1 at cycle 5+2+4. relay_reset_req 1-cycle pulse, state=2.
- Breaker failure: trip_signal=1, raw held closed -> trip_coil high 16 cycles. breaker_fail=1, lockout=1, state=4 at cycle 80; manual_close ignored until reset_n low.
- Debounce: raw glitch low for 3 cycles in CLOSED -> no state change. Low for 6 cycles -> state=OPEN.
- Close/trip priority: in OPEN, manual_close rising with trip_signal=0 -> close_coil=1. Assert trip_signal at timer=3 -> close_coil=0 and trip_coil=1 on the same edge.
- Reset mid-pulse: reset_n low at trip_coil cycle 7 -> all outputs 0 asynchronously, state=0 after release.
- AUTO_RECLOSE_EN:
  - trip, open -> close_coil at 400 cycles after OPEN.
  - Second trip within 400 cycles of reclose -> lockout=1, breaker_fail=0.

Source files
------------

// File: rtl/breaker_trip_interface.sv
// -----------------------------------------------------------------------------
// breaker_trip_interface
//
// Breaker-side companion to the latching instantaneous overcurrent relay.
// It takes the relay's latched trip request and drives the breaker trip and
// close coils. It watches the 52a auxiliary contact through a synchroniser
// and a debounce filter, and flags breaker failure when the contact does not
// follow a coil command in time. When the breaker is confirmed open after a
// trip, it sends the relay a one-cycle pulse that clears the relay latch.
// Everything runs in the 800 Hz system clock domain.
//
// Ports:
//   clk_800hz          in   800 Hz system clock
//   reset_n            in   asynchronous assert, synchronous release, active low
//   trip_signal        in   latched trip from the overcurrent relay
//   breaker_closed_raw in   52a auxiliary contact (asynchronous), 1 = closed
//   manual_close       in   operator close request (level; rising edge used)
//   trip_coil          out  trip coil drive
//   close_coil         out  close coil drive
//   breaker_open       out  debounced breaker status, 1 = open
//   relay_reset_req    out  one-cycle pulse that clears the relay latch
//   breaker_fail       out  latched breaker-failure flag
//   lockout            out  lockout flag, cleared only by reset_n
//   state              out  FSM state: CLOSED=0 TRIPPING=1 OPEN=2 CLOSING=3
//                           LOCKOUT=4
//
// Build option:
//   AUTO_RECLOSE_EN  define to enable the one-shot auto-reclose. When it is
//                    undefined only manual_close can reclose the breaker.
// -----------------------------------------------------------------------------
module breaker_trip_interface #(
  parameter int unsigned COIL_PULSE_CYC    = 16,   // coil energise length
  parameter int unsigned BF_TIMEOUT_CYC    = 80,   // contact confirmation window
  parameter int unsigned DEBOUNCE_CYC      = 4,    // equal samples to accept a change
  parameter int unsigned RECLOSE_DELAY_CYC = 400,  // auto-reclose dead/reclaim time
  parameter int unsigned CNT_W             = 12    // state timer width
) (
  input  logic       clk_800hz,
  input  logic       reset_n,
  input  logic       trip_signal,
  input  logic       breaker_closed_raw,
  input  logic       manual_close,
  output logic       trip_coil,
  output logic       close_coil,
  output logic       breaker_open,
  output logic       relay_reset_req,
  output logic       breaker_fail,
  output logic       lockout,
  output logic [2:0] state
);

  // ---------------------------------------------------------------------------
  // Encodings and derived constants
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_CLOSED   = 3'd0;
  localparam logic [2:0] ST_TRIPPING = 3'd1;
  localparam logic [2:0] ST_OPEN     = 3'd2;
  localparam logic [2:0] ST_CLOSING  = 3'd3;
  localparam logic [2:0] ST_LOCKOUT  = 3'd4;

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC) + 1;

  // The timer reads 0 on the entry edge, so a count of N cycles ends on the
  // edge that leaves the timer at N-1.
  localparam logic [CNT_W-1:0] COIL_LEN = CNT_W'(COIL_PULSE_CYC);
  localparam logic [CNT_W-1:0] BF_LAST  = CNT_W'(BF_TIMEOUT_CYC - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
`ifdef AUTO_RECLOSE_EN
  localparam logic [CNT_W-1:0] RECLOSE_LAST = CNT_W'(RECLOSE_DELAY_CYC - 1);
`endif

  // Elaboration-time sanity checks on the parameter set.
  if (BF_TIMEOUT_CYC <= COIL_PULSE_CYC) begin : g_bad_bf_timeout
    $error("BF_TIMEOUT_CYC must exceed COIL_PULSE_CYC");
  end
  if (DEBOUNCE_CYC == 0) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be at least 1");
  end
  if ((64'd1 << CNT_W) <= 64'(BF_TIMEOUT_CYC) ||
      (64'd1 << CNT_W) <= 64'(RECLOSE_DELAY_CYC)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the cycle parameters");
  end

  // ---------------------------------------------------------------------------
  // Contact path: 2-FF synchroniser followed by a debounce filter
  // ---------------------------------------------------------------------------
  logic            sync1_q, sync2_q;
  logic            db_closed_q, db_closed_d;
  logic [DB_W-1:0] db_cnt_q,    db_cnt_d;

  // NOTE: the synchroniser and debounce flops reset to "closed" rather than 0,
  // so a breaker that is closed at power-up does not look like an opening.
  always_ff @(posedge clk_800hz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      db_closed_q <= 1'b1;
      db_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would collapse the two synchroniser stages into one.
      sync1_q     <= breaker_closed_raw;
      sync2_q     <= sync1_q;
      db_closed_q <= db_closed_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  // The counter advances while the synchronised sample disagrees with the
  // accepted value and restarts on any agreeing sample. The value flips on
  // the DEBOUNCE_CYC-th disagreeing sample.
  always_comb begin
    // NOTE: every signal gets a default before the conditions below; a path
    // that leaves one unassigned would infer a latch.
    db_closed_d = db_closed_q;
    db_cnt_d    = '0;
    if (sync2_q != db_closed_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_closed_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operator close edge detect
  // ---------------------------------------------------------------------------
  logic manual_close_q;
  logic close_rise;

  always_ff @(posedge clk_800hz or negedge reset_n) begin
    if (!reset_n) begin
      manual_close_q <= 1'b0;
    end else begin
      manual_close_q <= manual_close;
    end
  end

  assign close_rise = manual_close & ~manual_close_q;

  // ---------------------------------------------------------------------------
  // Main FSM, state timer and registered outputs
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q,           state_d;
  logic [CNT_W-1:0] timer_q,           timer_d;
  logic             trip_coil_q,       trip_coil_d;
  logic             close_coil_q,      close_coil_d;
  logic             breaker_open_q,    breaker_open_d;
  logic             relay_reset_req_q, relay_reset_req_d;
  logic             breaker_fail_q,    breaker_fail_d;
  logic             lockout_q,         lockout_d;
`ifdef AUTO_RECLOSE_EN
  logic             shot_used_q,       shot_used_d;
  logic             reclose_arm_q,     reclose_arm_d;
`endif

  // Transitions act on db_closed_d, the value the debounce register takes on
  // this same edge, so the state and breaker_open move together with the
  // accepted contact change instead of one cycle behind it.
  always_comb begin
    state_d           = state_q;
    relay_reset_req_d = 1'b0;
    breaker_fail_d    = breaker_fail_q;
`ifdef AUTO_RECLOSE_EN
    shot_used_d       = shot_used_q;
    reclose_arm_d     = reclose_arm_q;
`endif

    case (state_q)
      ST_CLOSED: begin
        // A trip wins over a contact that opens on the same edge; TRIPPING
        // then sees the open contact one cycle later and asks for the reset.
        if (trip_signal) begin
          state_d = ST_TRIPPING;
        end else if (!db_closed_d) begin
          state_d = ST_OPEN;  // spontaneous opening, relay latch untouched
        end
      end

      ST_TRIPPING: begin
        // The contact is checked before the timeout so a confirmation that
        // lands on the timeout edge is not reported as a failure.
        if (!db_closed_d) begin
          relay_reset_req_d = 1'b1;
`ifdef AUTO_RECLOSE_EN
          if (shot_used_q) begin
            state_d = ST_LOCKOUT;  // trip after the reclose shot: no retry
          end else begin
            state_d       = ST_OPEN;
            reclose_arm_d = 1'b1;
          end
`else
          state_d = ST_OPEN;
`endif
        end else if (timer_q >= BF_LAST) begin
          state_d        = ST_LOCKOUT;
          breaker_fail_d = 1'b1;
        end
      end

      ST_OPEN: begin
        // A close request that arrives while the relay still holds a trip is
        // dropped, not queued.
        if (db_closed_d) begin
          state_d = ST_CLOSED;
        end else if (close_rise && !trip_signal) begin
          state_d = ST_CLOSING;
`ifdef AUTO_RECLOSE_EN
        end else if (reclose_arm_q && (timer_q >= RECLOSE_LAST) && !trip_signal) begin
          state_d     = ST_CLOSING;
          shot_used_d = 1'b1;
`endif
        end
      end

      ST_CLOSING: begin
        if (trip_signal) begin
          state_d = ST_TRIPPING;
        end else if (db_closed_d) begin
          state_d = ST_CLOSED;
        end else if (timer_q >= BF_LAST) begin
          state_d        = ST_LOCKOUT;
          breaker_fail_d = 1'b1;
        end
      end

      ST_LOCKOUT: begin
        state_d = ST_LOCKOUT;
      end

      // Unreachable encodings fall into the safe, latched condition.
      default: begin
        state_d = ST_LOCKOUT;
      end
    endcase

`ifdef AUTO_RECLOSE_EN
    // The reclose opportunity belongs to one visit of OPEN only.
    if (state_d != ST_OPEN) begin
      reclose_arm_d = 1'b0;
    end
    // The shot is given back after a full reclaim period in CLOSED.
    if ((state_q == ST_CLOSED) && (state_d == ST_CLOSED) && (timer_q >= RECLOSE_LAST)) begin
      shot_used_d = 1'b0;
    end
`endif

    // Timer restarts on each state entry and saturates at all-ones.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + CNT_W'(1);
    end else begin
      timer_d = timer_q;
    end

    // Coil drives come from the next state and next timer value, which makes
    // the two coils mutually exclusive by construction and lets the trip coil
    // rise on the very edge that leaves CLOSING.
    trip_coil_d    = (state_d == ST_TRIPPING) && (timer_d < COIL_LEN);
    close_coil_d   = (state_d == ST_CLOSING)  && (timer_d < COIL_LEN);
    breaker_open_d = ~db_closed_d;
    lockout_d      = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk_800hz or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_CLOSED;
      timer_q           <= '0;
      trip_coil_q       <= 1'b0;
      close_coil_q      <= 1'b0;
      breaker_open_q    <= 1'b0;
      relay_reset_req_q <= 1'b0;
      breaker_fail_q    <= 1'b0;
      lockout_q         <= 1'b0;
`ifdef AUTO_RECLOSE_EN
      shot_used_q       <= 1'b0;
      reclose_arm_q     <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      trip_coil_q       <= trip_coil_d;
      close_coil_q      <= close_coil_d;
      breaker_open_q    <= breaker_open_d;
      relay_reset_req_q <= relay_reset_req_d;
      breaker_fail_q    <= breaker_fail_d;
      lockout_q         <= lockout_d;
`ifdef AUTO_RECLOSE_EN
      shot_used_q       <= shot_used_d;
      reclose_arm_q     <= reclose_arm_d;
`endif
    end
  end

  assign trip_coil       = trip_coil_q;
  assign close_coil      = close_coil_q;
  assign breaker_open    = breaker_open_q;
  assign relay_reset_req = relay_reset_req_q;
  assign breaker_fail    = breaker_fail_q;
  assign lockout         = lockout_q;
  assign state           = state_q;

endmodule

// File: tb/tb_breaker_trip_interface.sv
// -----------------------------------------------------------------------------
// tb_breaker_trip_interface
//
// Directed bench for breaker_trip_interface with hand-computed expectations.
// Edge numbering in the comments: "edge 0" is the clock edge at which the
// FSM enters the state under test; inputs are changed 1 time unit after an
// edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_breaker_trip_interface;

  localparam logic [2:0] ST_CLOSED   = 3'd0;
  localparam logic [2:0] ST_TRIPPING = 3'd1;
  localparam logic [2:0] ST_OPEN     = 3'd2;
  localparam logic [2:0] ST_CLOSING  = 3'd3;
  localparam logic [2:0] ST_LOCKOUT  = 3'd4;

  logic       clk_800hz = 1'b0;
  logic       reset_n;
  logic       trip_signal;
  logic       breaker_closed_raw;
  logic       manual_close;
  logic       trip_coil;
  logic       close_coil;
  logic       breaker_open;
  logic       relay_reset_req;
  logic       breaker_fail;
  logic       lockout;
  logic [2:0] state;

  int n_checks = 0;
  int n_bad    = 0;

  breaker_trip_interface dut (
    .clk_800hz          (clk_800hz),
    .reset_n            (reset_n),
    .trip_signal        (trip_signal),
    .breaker_closed_raw (breaker_closed_raw),
    .manual_close       (manual_close),
    .trip_coil          (trip_coil),
    .close_coil         (close_coil),
    .breaker_open       (breaker_open),
    .relay_reset_req    (relay_reset_req),
    .breaker_fail       (breaker_fail),
    .lockout            (lockout),
    .state              (state)
  );

  always #5 clk_800hz = ~clk_800hz;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_800hz);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset_n            = 1'b0;
    trip_signal        = 1'b0;
    breaker_closed_raw = 1'b1;
    manual_close       = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  // The two coils must never be driven together.
  always @(negedge clk_800hz) begin
    if (reset_n === 1'b1 && trip_coil === 1'b1 && close_coil === 1'b1) begin
      check("coil_excl", 1, 0);
    end
  end

  initial begin
    reset_n            = 1'b0;
    trip_signal        = 1'b0;
    breaker_closed_raw = 1'b1;
    manual_close       = 1'b0;
    step(2);

    // ---------------- reset state ----------------
    check("rst_state",   int'(state), int'(ST_CLOSED));
    check("rst_trip",    int'(trip_coil), 0);
    check("rst_close",   int'(close_coil), 0);
    check("rst_open",    int'(breaker_open), 0);
    check("rst_fail",    int'(breaker_fail), 0);
    check("rst_lockout", int'(lockout), 0);
    reset_n = 1'b1;
    step(3);
    check("post_rst_state", int'(state), int'(ST_CLOSED));
    check("post_rst_req",   int'(relay_reset_req), 0);

    // ---------------- trip with contact confirming at 5+2+4 ----------------
    trip_signal = 1'b1;
    step(1);                                   // edge 0
    check("trip_state", int'(state), int'(ST_TRIPPING));
    check("trip_coil0", int'(trip_coil), 1);
    step(5);                                   // edge 5
    breaker_closed_raw = 1'b0;
    step(5);                                   // edge 10
    check("trip_pre_state", int'(state), int'(ST_TRIPPING));
    check("trip_pre_open",  int'(breaker_open), 0);
    check("trip_coil10",    int'(trip_coil), 1);
    step(1);                                   // edge 11
    check("trip_open_state", int'(state), int'(ST_OPEN));
    check("trip_open_flag",  int'(breaker_open), 1);
    check("trip_rr_pulse",   int'(relay_reset_req), 1);
    check("trip_coil_off",   int'(trip_coil), 0);
    trip_signal = 1'b0;
    step(1);                                   // edge 12
    check("trip_rr_end", int'(relay_reset_req), 0);

    // ---------------- close then trip priority ----------------
    manual_close = 1'b1;
    step(1);                                   // CLOSING entry, timer 0
    check("cls_state", int'(state), int'(ST_CLOSING));
    check("cls_coil",  int'(close_coil), 1);
    step(3);                                   // timer 3
    trip_signal  = 1'b1;
    manual_close = 1'b0;
    step(1);
    check("prio_state", int'(state), int'(ST_TRIPPING));
    check("prio_close", int'(close_coil), 0);
    check("prio_trip",  int'(trip_coil), 1);
    step(1);                                   // contact already open
    check("prio_open_state", int'(state), int'(ST_OPEN));
    check("prio_rr",         int'(relay_reset_req), 1);
    trip_signal = 1'b0;

`ifdef AUTO_RECLOSE_EN
    // ---------------- auto-reclose: close 400 cycles after OPEN ----------------
    step(399);
    check("ar_wait_state", int'(state), int'(ST_OPEN));
    check("ar_wait_close", int'(close_coil), 0);
    step(1);
    check("ar_reclose_state", int'(state), int'(ST_CLOSING));
    check("ar_reclose_coil",  int'(close_coil), 1);
    breaker_closed_raw = 1'b1;
    step(6);
    check("ar_closed_state", int'(state), int'(ST_CLOSED));
    check("ar_closed_coil",  int'(close_coil), 0);
    step(10);
    trip_signal = 1'b1;                        // second trip inside reclaim
    step(1);
    check("ar_trip2_state", int'(state), int'(ST_TRIPPING));
    breaker_closed_raw = 1'b0;
    step(6);
    check("ar_lock_state", int'(state), int'(ST_LOCKOUT));
    check("ar_lock_flag",  int'(lockout), 1);
    check("ar_lock_fail",  int'(breaker_fail), 0);
    check("ar_lock_rr",    int'(relay_reset_req), 1);
`else
    // ---------------- no auto-reclose in the default build ----------------
    step(420);
    check("noar_state", int'(state), int'(ST_OPEN));
    check("noar_close", int'(close_coil), 0);
`endif

    // ---------------- debounce ----------------
    apply_reset();
    breaker_closed_raw = 1'b0;                 // 3-cycle glitch
    step(3);
    breaker_closed_raw = 1'b1;
    step(8);
    check("glitch_state", int'(state), int'(ST_CLOSED));
    check("glitch_open",  int'(breaker_open), 0);
    breaker_closed_raw = 1'b0;                 // real opening
    step(5);
    check("db5_state", int'(state), int'(ST_CLOSED));
    step(1);
    check("db6_state", int'(state), int'(ST_OPEN));
    check("db6_open",  int'(breaker_open), 1);
    check("db6_rr",    int'(relay_reset_req), 0);
    breaker_closed_raw = 1'b1;                 // spontaneous re-close
    step(6);
    check("reclose_state", int'(state), int'(ST_CLOSED));
    check("reclose_open",  int'(breaker_open), 0);

    // ---------------- breaker failure ----------------
    apply_reset();
    trip_signal = 1'b1;
    step(1);                                   // edge 0
    check("bf_coil0", int'(trip_coil), 1);
    step(15);                                  // edge 15
    check("bf_coil15", int'(trip_coil), 1);
    step(1);                                   // edge 16
    check("bf_coil16", int'(trip_coil), 0);
    step(63);                                  // edge 79
    check("bf79_state", int'(state), int'(ST_TRIPPING));
    check("bf79_fail",  int'(breaker_fail), 0);
    step(1);                                   // edge 80
    check("bf80_state",   int'(state), int'(ST_LOCKOUT));
    check("bf80_fail",    int'(breaker_fail), 1);
    check("bf80_lockout", int'(lockout), 1);
    trip_signal  = 1'b0;
    manual_close = 1'b1;
    step(4);
    check("bf_ign_state", int'(state), int'(ST_LOCKOUT));
    check("bf_ign_close", int'(close_coil), 0);
    reset_n = 1'b0;
    #1;
    check("bf_rst_state",   int'(state), int'(ST_CLOSED));
    check("bf_rst_fail",    int'(breaker_fail), 0);
    check("bf_rst_lockout", int'(lockout), 0);

    // ---------------- reset mid-pulse ----------------
    apply_reset();
    trip_signal = 1'b1;
    step(1);                                   // edge 0
    step(7);                                   // edge 7
    check("mid_coil7", int'(trip_coil), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_async_coil",  int'(trip_coil), 0);
    check("mid_async_state", int'(state), int'(ST_CLOSED));
    trip_signal = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    check("mid_rel_state", int'(state), int'(ST_CLOSED));
    check("mid_rel_coil",  int'(trip_coil), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
